// File: rtl/wb_addr_decode_if.sv
// Bus bundle for wb_addr_decode: address/cycle request and slave acks in,
// per-channel selects, ack/err pulses and owning-channel index out.
interface wb_addr_decode_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic [WIDTH-1:0]    addr;
    logic                wb_cyc;
    logic [CHANNELS-1:0] slave_ack;
    logic [CHANNELS-1:0] cyc;
    logic                ack;
    logic                err;
    logic [2:0]          sel;

    modport master (
        output addr, wb_cyc, slave_ack,
        input  cyc, ack, err, sel
    );

    modport slave (
        input  addr, wb_cyc, slave_ack,
        output cyc, ack, err, sel
    );
endinterface

// File: rtl/wb_addr_decode.sv
// Wishbone address decoder: lowest-index base/mask match selects a channel,
// then acks internally after LATENCY clocks or waits for the slave with a
// timeout. Ports: wb_ck, wb_rst (sync, active high), bus (slave modport).
module wb_addr_decode #(
    parameter int                        CHANNELS = 4,
    parameter int                        WIDTH    = 8,
    parameter logic [CHANNELS*WIDTH-1:0] BASE     = {8'h03, 8'h02, 8'h01, 8'h00},
    parameter logic [CHANNELS*WIDTH-1:0] MASK     = '1,
    parameter logic [CHANNELS-1:0]       EXT_ACK  = '0,
    parameter int                        LATENCY  = 1,
    parameter int                        TIMEOUT  = 16
) (
    input logic             wb_ck,
    input logic             wb_rst,
    wb_addr_decode_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic [2:0]          sel_q;
    logic                hit_q;
    logic                ack_q;
    logic                err_q;

    logic [CHANNELS-1:0] match;
    logic                hit;
    logic [2:0]          idx;
    logic                changed;
    logic [7:0]          ext8;
    logic [7:0]          sack8;
    logic [7:0]          cyc8;

    // Widen per-channel vectors to 8 bits so a 3-bit index is always legal.
    assign ext8  = 8'(EXT_ACK);
    assign sack8 = 8'(bus.slave_ack);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            match[i] = (bus.addr & MASK[i*WIDTH +: WIDTH])
                    == (BASE[i*WIDTH +: WIDTH] & MASK[i*WIDTH +: WIDTH]);
        end
    end

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = 3'(i);
            end
        end
    end

    always_comb begin
        cyc8 = '0;
        if (bus.wb_cyc && hit) begin
            cyc8 = 8'd1 << idx;
        end
    end

    assign bus.cyc = cyc8[CHANNELS-1:0];

    // An unmapped address owns the transfer as "no channel"; becoming
    // mapped, or moving to another channel, ends the transfer.
    assign changed = (hit != hit_q) || (hit && (idx != sel_q));

    always_ff @(posedge wb_ck) begin
        if (wb_rst) begin
            state <= IDLE;
            cnt   <= '0;
            sel_q <= '0;
            hit_q <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wb_cyc) begin
                        hit_q <= hit;
                        if (!hit) begin
                            sel_q <= '0;
                            err_q <= 1'b1;
                            state <= HOLD;
                        end else begin
                            sel_q <= idx;
                            if (ext8[idx]) begin
                                cnt   <= 8'(TIMEOUT - 1);
                                state <= WAIT;
                            end else if (LATENCY == 1) begin
                                ack_q <= 1'b1;
                                state <= HOLD;
                            end else begin
                                cnt   <= 8'(LATENCY - 1);
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!bus.wb_cyc || changed) begin
                        state <= IDLE;
                        cnt   <= '0;
                        sel_q <= '0;
                        hit_q <= 1'b0;
                    end else if (ext8[sel_q] && sack8[sel_q]) begin
                        ack_q <= 1'b1;
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt == 8'd1) begin
                        // Counter expires on this edge.
                        ack_q <= !ext8[sel_q];
                        err_q <= ext8[sel_q];
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (!bus.wb_cyc || changed) begin
                        state <= IDLE;
                        sel_q <= '0;
                        hit_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack = ack_q;
    assign bus.err = err_q;
    assign bus.sel = sel_q;

endmodule
